// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests, rides out
// multi-cycle misses and drives the IF/ID write-enable / clear controls.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_re,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] ifid_pcinc,
  output logic [15:0] ifid_inst,
  output logic        ifid_we,
  output logic        ifid_clr,
  output logic        halted
);

  localparam int unsigned XLEN = 16;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_MISS  = 3'd1;
  localparam logic [2:0] ST_BUF   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] buf_inst_q, buf_inst_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            halted_q, halted_d;

  logic            re_c, we_c, clr_c, deliver_c;
  logic [XLEN-1:0] inst_c;
  logic [XLEN-1:0] pcinc_c;

  assign pcinc_c = XLEN'(pc_q + PC_STEP);

  // Next-state and per-cycle IF/ID control
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_inst_d = buf_inst_q;
    tgt_d      = tgt_q;
    re_c       = 1'b0;
    we_c       = 1'b0;
    clr_c      = 1'b0;
    deliver_c  = 1'b0;
    inst_c     = imem_rdata;

    case (state_q)
      ST_FETCH: begin
        re_c = 1'b1;
        if (redirect) begin
          clr_c = 1'b1;
          if (imem_ready) begin
            pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = ST_DRAIN;
          end
        end else if (stall) begin
          if (!imem_ready) state_d = ST_MISS;
        end else if (imem_ready) begin
          deliver_c = 1'b1;
        end else begin
          clr_c   = 1'b1;
          state_d = ST_MISS;
        end
      end
      ST_MISS: begin
        re_c = 1'b1;
        if (redirect) begin
          clr_c = 1'b1;
          if (imem_ready) begin
            pc_d    = redirect_pc;
            state_d = ST_FETCH;
          end else begin
            tgt_d   = redirect_pc;
            state_d = ST_DRAIN;
          end
        end else if (imem_ready) begin
          if (stall) begin
            buf_inst_d = imem_rdata;
            state_d    = ST_BUF;
          end else begin
            deliver_c = 1'b1;
          end
        end else begin
          clr_c = !stall;
        end
      end
      ST_BUF: begin
        inst_c = buf_inst_q;
        if (redirect) begin
          clr_c   = 1'b1;
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end else if (!stall) begin
          deliver_c = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Committed fill to a wrong-path address: wait it out, then jump
        re_c  = 1'b1;
        clr_c = 1'b1;
        if (redirect) tgt_d = redirect_pc;
        if (imem_ready) begin
          pc_d    = redirect ? redirect_pc : tgt_q;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        clr_c = redirect || !stall;
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (deliver_c) begin
      we_c    = 1'b1;
      clr_c   = 1'b0;
      pc_d    = pcinc_c;
      state_d = (inst_c[15:12] == HALT_OPC) ? ST_HALT : ST_FETCH;
    end

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      buf_inst_q <= '0;
      tgt_q      <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_inst_q <= buf_inst_d;
      tgt_q      <= tgt_d;
      halted_q   <= halted_d;
    end
  end

  // Reset forces an idle memory port and a bubble into IF/ID
  assign imem_re    = rst_n && re_c;
  assign ifid_we    = rst_n && we_c;
  assign ifid_clr   = !rst_n || clr_c;
  assign imem_addr  = pc_q;
  assign ifid_pcinc = pcinc_c;
  assign ifid_inst  = inst_c;
  assign halted     = halted_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_re;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic [15:0] ifid_pcinc;
  logic [15:0] ifid_inst;
  logic        ifid_we;
  logic        ifid_clr;
  logic        halted;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_re(imem_re), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .ifid_pcinc(ifid_pcinc),
    .ifid_inst(ifid_inst), .ifid_we(ifid_we), .ifid_clr(ifid_clr), .halted(halted)
  );

  typedef struct packed {
    logic        re;
    logic [15:0] addr;
    logic        we;
    logic        clr;
    logic [15:0] pcinc;
    logic [15:0] inst;
    logic        halt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the outputs expected for that cycle
  task automatic step(input string nm, input logic rs, input logic st, input logic rd,
                      input logic [15:0] rpc, input logic rdy, input logic [15:0] rdata,
                      input logic e_re, input logic [15:0] e_addr, input logic e_we,
                      input logic e_clr, input logic [15:0] e_pcinc,
                      input logic [15:0] e_inst, input logic e_halt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = rs;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = rdata;
    e = '{re: e_re, addr: e_addr, we: e_we, clr: e_clr, pcinc: e_pcinc,
          inst: e_inst, halt: e_halt};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{re: imem_re, addr: imem_addr, we: ifid_we, clr: ifid_clr,
             pcinc: ifid_pcinc, inst: ifid_inst, halt: halted};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got re=%b addr=%h we=%b clr=%b pcinc=%h inst=%h halted=%b, want re=%b addr=%h we=%b clr=%b pcinc=%h inst=%h halted=%b",
                 nm, a.re, a.addr, a.we, a.clr, a.pcinc, a.inst, a.halt,
                 e.re, e.addr, e.we, e.clr, e.pcinc, e.inst, e.halt);
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_ready = 1'b0; imem_rdata = 16'h0;

    //   name        rs st rd rpc       rdy rdata     re addr      we clr pcinc     inst      h
    step("reset0",   0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0002, 16'h0000, 0);
    step("reset1",   0, 0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0000, 0, 1, 16'h0002, 16'h1111, 0);
    // T1 back-to-back hits
    step("t1_hit0",  1, 0, 0, 16'h0000, 1, 16'hA000, 1, 16'h0000, 1, 0, 16'h0002, 16'hA000, 0);
    step("t1_hit1",  1, 0, 0, 16'h0000, 1, 16'hA001, 1, 16'h0002, 1, 0, 16'h0004, 16'hA001, 0);
    // T2 four-cycle miss at 0004
    step("t2_miss0", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 1, 16'h0006, 16'h0000, 0);
    step("t2_miss1", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 1, 16'h0006, 16'h0000, 0);
    step("t2_miss2", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 1, 16'h0006, 16'h0000, 0);
    step("t2_miss3", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 1, 16'h0006, 16'h0000, 0);
    step("t2_fill",  1, 0, 0, 16'h0000, 1, 16'hA002, 1, 16'h0004, 1, 0, 16'h0006, 16'hA002, 0);
    // T3 miss completes under stall into BUF
    step("t3_stmis", 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, 0, 16'h0008, 16'h0000, 0);
    step("t3_stwt",  1, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, 0, 16'h0008, 16'h0000, 0);
    step("t3_tobuf", 1, 1, 0, 16'h0000, 1, 16'hA003, 1, 16'h0006, 0, 0, 16'h0008, 16'hA003, 0);
    step("t3_bufst", 1, 1, 0, 16'h0000, 0, 16'h1234, 0, 16'h0006, 0, 0, 16'h0008, 16'hA003, 0);
    step("t3_bufdl", 1, 0, 0, 16'h0000, 0, 16'h1234, 0, 16'h0006, 1, 0, 16'h0008, 16'hA003, 0);
    // T5 HLT then redirect out of HALT
    step("t5_hlt",   1, 0, 0, 16'h0000, 1, 16'hF000, 1, 16'h0008, 1, 0, 16'h000A, 16'hF000, 0);
    step("t5_halt",  1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h000A, 0, 1, 16'h000C, 16'h0000, 1);
    step("t5_hltst", 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h000A, 0, 0, 16'h000C, 16'h0000, 1);
    step("t5_redir", 1, 0, 1, 16'h0010, 0, 16'h0000, 0, 16'h000A, 0, 1, 16'h000C, 16'h0000, 1);
    step("t5_resum", 1, 0, 0, 16'h0000, 1, 16'h0100, 1, 16'h0010, 1, 0, 16'h0012, 16'h0100, 0);
    // T4 redirect during a miss drains the committed fill
    step("t4_miss",  1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 0, 1, 16'h0014, 16'h0000, 0);
    step("t4_redir", 1, 0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0012, 0, 1, 16'h0014, 16'h0000, 0);
    step("t4_drain", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0012, 0, 1, 16'h0014, 16'h0000, 0);
    step("t4_drdy",  1, 0, 0, 16'h0000, 1, 16'h5555, 1, 16'h0012, 0, 1, 16'h0014, 16'h5555, 0);
    step("t4_tgt",   1, 0, 0, 16'h0000, 1, 16'h0200, 1, 16'h0040, 1, 0, 16'h0042, 16'h0200, 0);
    // Newest redirect wins inside DRAIN
    step("nw_redir", 1, 0, 1, 16'h0060, 0, 16'h0000, 1, 16'h0042, 0, 1, 16'h0044, 16'h0000, 0);
    step("nw_drrdy", 1, 0, 1, 16'h0070, 1, 16'h6666, 1, 16'h0042, 0, 1, 16'h0044, 16'h6666, 0);
    step("nw_tgt",   1, 0, 0, 16'h0000, 1, 16'h0300, 1, 16'h0070, 1, 0, 16'h0072, 16'h0300, 0);
    // Stall on a hit drops the data and refetches
    step("st_hit",   1, 1, 0, 16'h0000, 1, 16'h0400, 1, 16'h0072, 0, 0, 16'h0074, 16'h0400, 0);
    step("st_refch", 1, 0, 0, 16'h0000, 1, 16'h0400, 1, 16'h0072, 1, 0, 16'h0074, 16'h0400, 0);
    // T6 PC wrap and reset mid-miss
    step("t6_redir", 1, 0, 1, 16'hFFFE, 1, 16'h7777, 1, 16'h0074, 0, 1, 16'h0076, 16'h7777, 0);
    step("t6_wrap",  1, 0, 0, 16'h0000, 1, 16'h0500, 1, 16'hFFFE, 1, 0, 16'h0000, 16'h0500, 0);
    step("t6_hit0",  1, 0, 0, 16'h0000, 1, 16'h0600, 1, 16'h0000, 1, 0, 16'h0002, 16'h0600, 0);
    step("t6_miss0", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, 1, 16'h0004, 16'h0000, 0);
    step("t6_miss1", 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, 1, 16'h0004, 16'h0000, 0);
    step("t6_rst",   0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0002, 16'h0000, 0);
    step("t6_post",  1, 0, 0, 16'h0000, 1, 16'h0700, 1, 16'h0000, 1, 0, 16'h0002, 16'h0700, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never compared, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
